data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the processor's data-memory port. Accepts one
//  load or store request at a time over a valid/ready handshake and models
//  LATENCY wait states. Returns read data or a store acknowledge over a
//  valid/ready response channel.
//  Sits between the processor datapath and the word storage. It replaces the
//  zero-wait DataMemory when the multicycle datapath is brought up.
// PARAMETERS
//  DATA_W   64  width of a data word in bits (one 64-bit word per access)
//  DEPTH    32  number of words stored; byte address range is 0..DEPTH*8-1
//  LATENCY  2   wait cycles between request accept and response; 0..15 legal
// PORTS
//  clk        in   1       single clock, all state updates on its rising edge
//  reset_n    in   1       asynchronous, active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       responder can accept a request this cycle
//  req_write  in   1       1 = store, 0 = load
//  req_addr   in   64      byte address (the ALU result)
//  req_wdata  in   DATA_W  store data (register bank read port 2)
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       requester can take the response
//  rsp_rdata  out  DATA_W  load data; 0 for stores and for errors
//  rsp_error  out  1       access was misaligned or out of range
// BEHAVIOUR
//  Reset (reset_n low, any time, asynchronous):
//   - state=IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0.
//   - Wait counter = 0. Storage contents are NOT cleared.
//   - An in-flight access is dropped. An in-flight store that has not yet
//     committed never writes.
//  States:
//   - IDLE: req_ready=1. On req_valid&req_ready, latch write/addr/wdata.
//     Next state is WAIT if LATENCY>0, else RESP.
//   - WAIT: req_ready=0; counter increments each cycle. After LATENCY cycles
//     in WAIT, go to RESP.
//   - RESP: rsp_valid=1; rsp_rdata and rsp_error are stable while
//     rsp_valid=1 and rsp_ready=0. On rsp_ready, go to IDLE.
//  Latency: a request accepted at edge N gives rsp_valid=1 from cycle
//   N+1+LATENCY.
//  Error check (on latched addr):
//   - addr[2:0]!=0 (misaligned), or addr[63:3]>=DEPTH (out of range).
//   - Error => rsp_error=1, rsp_rdata=0, no storage write.
//  Store commit: the word at addr[63:3] is written on the WAIT->RESP (or
//   IDLE->RESP) edge, exactly once.
//  Load read: sampled on that same edge, so rsp_rdata reflects all earlier
//   committed stores.
//  Request channel: req_* is ignored while req_ready=0; no queueing. A new
//   request may be accepted the cycle after the response handshake.
//  Response channel: the rsp_valid&rsp_ready handshake completes in one
//   cycle. rsp_valid drops the next cycle and rsp_rdata/rsp_error return to 0.
// STRUCTURE
//  Package mem_resp_pkg:
//   - typedef enum logic[1:0] {IDLE, WAIT, RESP} mem_state_t.
//   - WORD_BYTES=8, WORD_SHIFT=3.
//   - function addr_ok(addr, depth) returning the error flag.
//  Sub-module word_ram:
//   - DEPTH x DATA_W synchronous-write, combinational-read array.
//   - Ports clk, we, waddr, wdata, raddr, rdata; no reset.
//  data_mem_responder holds the FSM, request latches, wait counter and
//   response registers.
// TESTING
//  1. Store 0x0123_4567_89AB_CDEF to addr 0x10 (LATENCY=2), rsp_ready=1:
//     rsp_valid at accept+3, rsp_error=0, rsp_rdata=0. A later load of 0x10
//     returns 0x0123_4567_89AB_CDEF.
//  2. Load addr 0x0C (misaligned) -> rsp_error=1, rsp_rdata=0.
//     Store to addr 0x100 (=DEPTH*8) -> rsp_error=1, and word 31 is unchanged.
//  3. Hold rsp_ready=0 for 5 cycles after rsp_valid. rsp_valid and rsp_rdata
//     stay stable and req_ready=0 throughout. A new req_valid in that window
//     is ignored.
//  4. Back-to-back: store 0xAA to 0x08, then a load of 0x08 presented the
//     cycle after the store response handshake -> accepted immediately and
//     returns 0xAA.
//  5. Pull reset_n low during WAIT of a store of 0x55 to 0x18 -> outputs go
//     to reset values immediately. After release, a load of 0x18 returns the
//     old value, not 0x55.
//  6. LATENCY=0 build: load accepted at edge N gives rsp_valid in cycle N+1.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state enum, word geometry and the address check.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   localparam int WORD_BYTES = 8;
   localparam int WORD_SHIFT = 3;

   // Returns 1 when the access must be rejected: the byte
   // address is not word aligned, or the word index is past
   // the end of storage.
   function automatic logic addr_ok(
      input logic [63:0] addr,
      input int          depth
   );
      logic [63:0] widx;
      widx = addr >> WORD_SHIFT;
      return (addr[2:0] != 3'd0) ||
             (widx >= 64'(unsigned'(depth)));
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between datapath and data memory.
// master = processor side, slave = memory responder side.
interface data_mem_responder_if #(
   parameter int DATA_W = 64
);

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [63:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_error;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      output rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      input  rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_error
   );

endinterface

// File: rtl/data_mem_responder_word_ram.sv
// Word storage: DEPTH x DATA_W, synchronous write, async read.
// Ports: clk, we, waddr, wdata, raddr, rdata. No reset.
module word_ram #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 32,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one access at a time, LATENCY waits.
// Ports: clk, reset_n, bus (slave side of the req/rsp bundle).
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int DEPTH   = 32,
   parameter int LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   data_mem_responder_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] LAT_LAST =
      4'(LATENCY == 0 ? 0 : LATENCY - 1);

   mem_state_t        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              write_q, write_d;
   logic [63:0]       addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              eff_write;
   logic [63:0]       eff_addr;
   logic [DATA_W-1:0] eff_wdata;
   logic              eff_err;
   logic              commit;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;

   // In IDLE a zero-latency access commits on its accept
   // edge, before the latches hold it, so use the live bus.
   always_comb begin
      eff_write = write_q;
      eff_addr  = addr_q;
      eff_wdata = wdata_q;
      if (state_q == IDLE) begin
         eff_write = bus.req_write;
         eff_addr  = bus.req_addr;
         eff_wdata = bus.req_wdata;
      end
      eff_err = addr_ok(eff_addr, DEPTH);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      commit  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               write_d = bus.req_write;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               cnt_d   = 4'd0;
               if (LATENCY == 0) begin
                  state_d = RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == LAT_LAST) begin
               state_d = RESP;
               cnt_d   = 4'd0;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      // Load data is sampled on the commit edge, so it sees
      // every store committed by earlier accesses.
      if (commit) begin
         err_d   = eff_err;
         rdata_d = (eff_write || eff_err) ? '0 : ram_rdata;
      end
   end

   assign ram_we = commit && eff_write && !eff_err;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   word_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (eff_addr[WORD_SHIFT +: AW]),
      .wdata (eff_wdata),
      .raddr (eff_addr[WORD_SHIFT +: AW]),
      .rdata (ram_rdata)
   );

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_error = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed and random accesses
// checked against a word-array reference model.
module tb_data_mem_responder;

   localparam int LAT   = 2;
   localparam int DEPTH = 32;

   logic clk;
   logic reset_n;

   data_mem_responder_if #(.DATA_W(64)) bus ();
   data_mem_responder_if #(.DATA_W(64)) bus0 ();

   data_mem_responder #(
      .DATA_W  (64),
      .DEPTH   (DEPTH),
      .LATENCY (LAT)
   ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   data_mem_responder #(
      .DATA_W  (64),
      .DEPTH   (DEPTH),
      .LATENCY (0)
   ) u_dut0 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus0)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] model [DEPTH];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_err(input logic [63:0] a);
      return (a % 8 != 0) || (a / 8 >= DEPTH);
   endfunction

   // Starts at posedge+#1, ends at posedge+#1 after the
   // response handshake, ready for the next request.
   task automatic do_req(input bit          wr,
                         input logic [63:0] addr,
                         input logic [63:0] wd,
                         input int          hold,
                         input bit          poke);
      bit          e_err;
      logic [63:0] e_rd;
      logic [63:0] rd0;
      int          k;
      e_err = is_err(addr);
      e_rd  = (wr || e_err) ? 64'd0 : model[int'(addr / 8)];
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      check("req_ready_idle", 64'(bus.req_ready), 64'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_addr  = {$urandom, $urandom};
      bus.req_wdata = {$urandom, $urandom};
      k = 0;
      while (!bus.rsp_valid && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("latency", 64'(k), 64'(LAT));
      check("rsp_error", 64'(bus.rsp_error), 64'(e_err));
      check("rsp_rdata", bus.rsp_rdata, e_rd);
      rd0 = bus.rsp_rdata;
      for (int h = 0; h < hold; h++) begin
         if (poke) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b1;
            bus.req_addr  = 64'h8;
            bus.req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
         end
         @(posedge clk); #1;
         check("hold_valid", 64'(bus.rsp_valid), 64'd1);
         check("hold_rdata", bus.rsp_rdata, rd0);
         check("hold_error", 64'(bus.rsp_error), 64'(e_err));
         check("hold_req_ready", 64'(bus.req_ready), 64'd0);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      check("post_valid", 64'(bus.rsp_valid), 64'd0);
      check("post_rdata", bus.rsp_rdata, 64'd0);
      check("post_error", 64'(bus.rsp_error), 64'd0);
      check("post_req_ready", 64'(bus.req_ready), 64'd1);
      if (wr && !e_err) model[int'(addr / 8)] = wd;
   endtask

   task automatic do_req0(input bit          wr,
                          input logic [63:0] addr,
                          input logic [63:0] wd,
                          input logic [63:0] e_rd,
                          input bit          e_err);
      bus0.req_valid = 1'b1;
      bus0.req_write = wr;
      bus0.req_addr  = addr;
      bus0.req_wdata = wd;
      check("l0_req_ready", 64'(bus0.req_ready), 64'd1);
      @(posedge clk); #1;
      bus0.req_valid = 1'b0;
      check("l0_rsp_valid", 64'(bus0.rsp_valid), 64'd1);
      check("l0_rsp_rdata", bus0.rsp_rdata, e_rd);
      check("l0_rsp_error", 64'(bus0.rsp_error), 64'(e_err));
      bus0.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus0.rsp_ready = 1'b0;
      check("l0_post_valid", 64'(bus0.rsp_valid), 64'd0);
   endtask

   initial begin
      logic [63:0] a;
      logic [63:0] d;
      int          r;
      reset_n        = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.rsp_ready  = 1'b0;
      bus0.req_valid = 1'b0;
      bus0.req_write = 1'b0;
      bus0.req_addr  = '0;
      bus0.req_wdata = '0;
      bus0.rsp_ready = 1'b0;
      #2;
      check("rst_req_ready", 64'(bus.req_ready), 64'd1);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
      check("rst_rsp_error", 64'(bus.rsp_error), 64'd0);
      #20;
      reset_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < DEPTH; i++) begin
         do_req(1'b1, 64'(i * 8), {$urandom, $urandom}, 0, 1'b0);
      end

      do_req(1'b1, 64'h10, 64'h0123_4567_89AB_CDEF, 0, 1'b0);
      do_req(1'b0, 64'h10, 64'h0, 0, 1'b0);
      check("t1_model", model[2], 64'h0123_4567_89AB_CDEF);

      do_req(1'b0, 64'h0C, 64'h0, 0, 1'b0);
      do_req(1'b1, 64'h100, 64'hDEAD_BEEF_0000_0001, 0, 1'b0);
      do_req(1'b0, 64'hF8, 64'h0, 0, 1'b0);

      do_req(1'b0, 64'h10, 64'h0, 5, 1'b1);
      do_req(1'b0, 64'h08, 64'h0, 0, 1'b0);

      do_req(1'b1, 64'h08, 64'hAA, 0, 1'b0);
      do_req(1'b0, 64'h08, 64'h0, 0, 1'b0);

      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 64'h18;
      bus.req_wdata = 64'h55;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      check("t5_waiting", 64'(bus.rsp_valid), 64'd0);
      reset_n = 1'b0;
      #1;
      check("t5_req_ready", 64'(bus.req_ready), 64'd1);
      check("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("t5_rsp_rdata", bus.rsp_rdata, 64'd0);
      check("t5_rsp_error", 64'(bus.rsp_error), 64'd0);
      @(posedge clk); #3;
      reset_n = 1'b1;
      @(posedge clk); #1;
      do_req(1'b0, 64'h18, 64'h0, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r < 7) begin
            a = 64'($urandom_range(0, DEPTH - 1)) << 3;
         end else if (r == 7) begin
            a = (64'($urandom_range(0, DEPTH - 1)) << 3) +
                64'($urandom_range(1, 7));
         end else if (r == 8) begin
            a = 64'($urandom_range(DEPTH, 4000)) << 3;
         end else begin
            a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
         end
         d = {$urandom, $urandom};
         do_req(1'($urandom_range(0, 1)), a, d,
                $urandom_range(0, 2), 1'b0);
      end

      d = {$urandom, $urandom};
      do_req0(1'b1, 64'h20, d, 64'd0, 1'b0);
      do_req0(1'b0, 64'h20, 64'd0, d, 1'b0);
      do_req0(1'b0, 64'h21, 64'd0, 64'd0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
